conv_psum_accum: RTL and testbench

Multi-lane partial-sum accumulator placed after the multi-channel convolution engine. It takes Lanes convolution results per beat from a stream that cannot be stalled, and reads the matching partial sums from a synchronous output SRAM. It writes back the saturated sum, or the raw result on the first pass. Pass mode (FIRST/ACCUM/LAST), base address, length and optional ReLU on the last pass are configured per pass, with start/busy/done control.

---
 rtl/conv_psum_accum_pkg.sv | 21 ++
 rtl/conv_psum_accum_if.sv | 31 +++
 rtl/conv_psum_accum_sat_adder.sv | 80 ++++++++
 rtl/conv_psum_accum.sv | 189 ++++++++++++++++++
 tb/tb_conv_psum_accum.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_psum_accum_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the partial-sum accumulator:
//   - pass mode encodings (cfg_mode values)
//   - control FSM state encoding (also exported on the debug state port)
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam logic [1:0] MODE_FIRST = 2'd0;  // write raw conv result
    localparam logic [1:0] MODE_ACCUM = 2'd1;  // old + conv, saturated
    localparam logic [1:0] MODE_LAST  = 2'd2;  // as ACCUM, optional ReLU
    // 2'd3 is reserved and behaves exactly like MODE_ACCUM.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

endpackage

// File: rtl/conv_psum_accum_if.sv
// ---------------------------------------------------------------------------
// conv_psum_accum_if
// Synchronous single-port-style SRAM bus used by the accumulator.
//   rd_en/rd_addr : read request, rd_data returned one cycle after rd_en
//   wr_en/wr_addr/wr_data : write, committed on the clock edge
// master = accumulator, slave = SRAM.
// Handshake: there is no ready/valid on this bus; the SRAM accepts every
// request on the edge it is presented and always returns read data exactly
// one cycle later.
// ---------------------------------------------------------------------------
interface conv_psum_accum_if #(
    parameter int AddrWidth = 16,
    parameter int WordWidth = 128
);
    logic                 rd_en;
    logic [AddrWidth-1:0] rd_addr;
    logic [WordWidth-1:0] rd_data;
    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [WordWidth-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/conv_psum_accum_sat_adder.sv
// ---------------------------------------------------------------------------
// psum_sat_adder
// One lane: signed saturating add a+b, optional ReLU after saturation, then
// AddLatency valid-tagged pipeline registers (AddLatency = 0 is pure comb).
// Ports:
//   clk, rst       : clock, async active-high reset (clears valids and data)
//   in_valid, a, b : operands and their valid tag
//   relu_en        : force negative results to zero
//   out_valid, out_data : delayed result and tag
// ---------------------------------------------------------------------------
module psum_sat_adder #(
    parameter int DataWidth  = 32,
    parameter int AddLatency = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [DataWidth-1:0] a,
    input  logic signed [DataWidth-1:0] b,
    input  logic                        relu_en,
    output logic                        out_valid,
    output logic        [DataWidth-1:0] out_data
);

    localparam logic [DataWidth-1:0] MaxVal = {1'b0, {(DataWidth-1){1'b1}}};
    localparam logic [DataWidth-1:0] MinVal = {1'b1, {(DataWidth-1){1'b0}}};

    logic [DataWidth:0]   sum_wide;
    logic [DataWidth-1:0] sat_val;
    logic [DataWidth-1:0] res_val;

    always_comb begin
        sum_wide = {a[DataWidth-1], a} + {b[DataWidth-1], b};
        // Overflow shows up as the two top bits of the widened sum differing;
        // the extra sign bit then tells which rail to clamp to.
        if (sum_wide[DataWidth] != sum_wide[DataWidth-1]) begin
            sat_val = sum_wide[DataWidth] ? MinVal : MaxVal;
        end else begin
            sat_val = sum_wide[DataWidth-1:0];
        end
        res_val = (relu_en && sat_val[DataWidth-1]) ? '0 : sat_val;
    end

    generate
        if (AddLatency == 0) begin : g_comb
            assign out_valid = in_valid;
            assign out_data  = res_val;
        end else begin : g_pipe
            logic [AddLatency-1:0] vld_q;
            logic [AddLatency-1:0] vld_d;
            logic [DataWidth-1:0]  dat_q [AddLatency];
            logic [DataWidth-1:0]  dat_d [AddLatency];

            always_comb begin
                vld_d[0] = in_valid;
                dat_d[0] = res_val;
                for (int i = 1; i < AddLatency; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = dat_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < AddLatency; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    dat_q <= dat_d;
                end
            end

            assign out_valid = vld_q[AddLatency-1];
            assign out_data  = dat_q[AddLatency-1];
        end
    endgenerate

endmodule

// File: rtl/conv_psum_accum.sv
// ---------------------------------------------------------------------------
// conv_psum_accum
// Multi-lane partial-sum accumulator behind the convolution engine. Each
// accepted beat reads the matching partial sum (except in FIRST mode), adds
// it lane-wise with saturation and writes the result back to the same
// address AddLatency+2 cycles after acceptance.
// Ports:
//   Clk, Rst            : clock, async active-high reset
//   cfg_start/mode/relu/base/len : per-pass configuration, latched on start
//   conv_data/conv_valid: unstallable result stream (lane 0 in LSBs)
//   mem                 : SRAM bus (master side)
//   busy, done          : pass in progress / one-cycle completion pulse
//   err_unexp           : sticky, beat seen outside RUN or past cfg_len
//   dbg_state           : current control state
// Handshake: conv_valid has no ready; a beat is consumed exactly when
// conv_valid is high while the FSM is in RUN, otherwise it is dropped and
// flagged on err_unexp.
// ---------------------------------------------------------------------------
module conv_psum_accum
    import conv_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int Lanes      = 4,
    parameter int AddrWidth  = 16,
    parameter int LenWidth   = 16,
    parameter int AddLatency = 2
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         cfg_start,
    input  logic [1:0]                   cfg_mode,
    input  logic                         cfg_relu,
    input  logic [AddrWidth-1:0]         cfg_base,
    input  logic [LenWidth-1:0]          cfg_len,
    input  logic [Lanes*DataWidth-1:0]   conv_data,
    input  logic                         conv_valid,
    conv_psum_accum_if.master            mem,
    output logic                         busy,
    output logic                         done,
    output logic                         err_unexp,
    output conv_state_e                  dbg_state
);

    localparam int WordWidth = Lanes * DataWidth;

    conv_state_e          state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic                 relu_q, relu_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [LenWidth-1:0]  in_cnt_q, in_cnt_d;
    logic [LenWidth-1:0]  out_cnt_q, out_cnt_d;
    logic                 err_q, err_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [WordWidth-1:0] s1_conv_q, s1_conv_d;
    logic                 wr_en_q, wr_en_d;
    logic [WordWidth-1:0] wr_data_q, wr_data_d;

    logic                 accept;
    logic [WordWidth-1:0] addend;
    logic                 relu_en;
    logic [Lanes-1:0]     lane_valid;
    logic [WordWidth-1:0] sum_data;

    assign accept  = conv_valid && (state_q == ST_RUN);
    // In FIRST mode the stored word is ignored so the same pipeline writes
    // the raw convolution result.
    assign addend  = (mode_q == MODE_FIRST) ? '0 : mem.rd_data;
    assign relu_en = relu_q && (mode_q == MODE_LAST);

    assign mem.rd_en   = accept && (mode_q != MODE_FIRST);
    assign mem.rd_addr = base_q + AddrWidth'(in_cnt_q);
    assign mem.wr_en   = wr_en_q;
    assign mem.wr_addr = base_q + AddrWidth'(out_cnt_q);
    assign mem.wr_data = wr_data_q;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err_unexp = err_q;
    assign dbg_state = state_q;

    generate
        for (genvar l = 0; l < Lanes; l++) begin : g_lane
            psum_sat_adder #(
                .DataWidth (DataWidth),
                .AddLatency(AddLatency)
            ) u_add (
                .clk      (Clk),
                .rst      (Rst),
                .in_valid (s1_valid_q),
                .a        (s1_conv_q[l*DataWidth +: DataWidth]),
                .b        (addend[l*DataWidth +: DataWidth]),
                .relu_en  (relu_en),
                .out_valid(lane_valid[l]),
                .out_data (sum_data[l*DataWidth +: DataWidth])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        relu_d     = relu_q;
        base_d     = base_q;
        len_d      = len_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        err_d      = err_q;
        s1_valid_d = accept;
        s1_conv_d  = conv_data;
        // All lanes carry the same tag; the AND keeps every lane's tag live.
        wr_en_d    = &lane_valid;
        wr_data_d  = sum_data;

        if (accept) begin
            in_cnt_d = in_cnt_q + 1'b1;
        end
        if (wr_en_q) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        // Outside RUN covers both idle-time beats and beats past cfg_len,
        // because RUN is left on the very edge the last beat is taken.
        if (conv_valid && (state_q != ST_RUN)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    mode_d    = cfg_mode;
                    relu_d    = cfg_relu;
                    base_d    = cfg_base;
                    len_d     = cfg_len;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    err_d     = conv_valid;
                    state_d   = (cfg_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && ((in_cnt_q + 1'b1) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_en_q && ((out_cnt_q + 1'b1) == len_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            relu_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_conv_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            relu_q     <= relu_d;
            base_q     <= base_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            err_q      <= err_d;
            s1_valid_q <= s1_valid_d;
            s1_conv_q  <= s1_conv_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_conv_psum_accum.sv
module tb_conv_psum_accum;
    import conv_pkg::*;

    localparam int DW    = 32;
    localparam int LANES = 4;
    localparam int W     = DW * LANES;
    localparam int AW    = 16;
    localparam int LW    = 16;
    localparam int AL    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cfg_start  = 1'b0;
    logic [1:0]    cfg_mode   = '0;
    logic          cfg_relu   = 1'b0;
    logic [AW-1:0] cfg_base   = '0;
    logic [LW-1:0] cfg_len    = '0;
    logic [W-1:0]  conv_data  = '0;
    logic          conv_valid = 1'b0;
    logic          busy, done, err_unexp;
    conv_state_e   dbg_state;

    conv_psum_accum_if #(.AddrWidth(AW), .WordWidth(W)) mem_if ();

    conv_psum_accum #(
        .DataWidth(DW), .Lanes(LANES), .AddrWidth(AW), .LenWidth(LW), .AddLatency(AL)
    ) dut (
        .Clk(clk), .Rst(rst),
        .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_relu(cfg_relu),
        .cfg_base(cfg_base), .cfg_len(cfg_len),
        .conv_data(conv_data), .conv_valid(conv_valid),
        .mem(mem_if),
        .busy(busy), .done(done), .err_unexp(err_unexp), .dbg_state(dbg_state)
    );

    // ---------------- SRAM model and reference memory ----------------
    logic [W-1:0] sram    [logic [AW-1:0]];
    logic [W-1:0] ref_mem [logic [AW-1:0]];

    always @(posedge clk) begin
        if (mem_if.rd_en) mem_if.rd_data <= sram.exists(mem_if.rd_addr) ? sram[mem_if.rd_addr] : '0;
        if (mem_if.wr_en) sram[mem_if.wr_addr] = mem_if.wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            exp_cyc_q[$];
    logic [AW-1:0] exp_rd_q[$];

    int checks = 0;
    int failures = 0;
    int last_wr_cyc = -100;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;

    logic [1:0]    p_mode;
    logic          p_relu;
    logic [AW-1:0] p_base;
    int            p_idx;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lanes4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Independent lane model: 64-bit math then clamp, ReLU only on LAST.
    function automatic logic [W-1:0] model(input logic [W-1:0] old, input logic [W-1:0] cv,
                                           input logic [1:0] mode, input logic relu);
        logic [W-1:0] r;
        longint a, b, s;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            a = (mode == MODE_FIRST) ? 0 : longint'($signed(old[l*DW +: DW]));
            b = longint'($signed(cv[l*DW +: DW]));
            s = a + b;
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            if (relu && mode == MODE_LAST && s < 0) s = 0;
            r[l*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_if.rd_en) begin
                rd_cnt++;
                check("rd_expected", W'(exp_rd_q.size() != 0), 1);
                if (exp_rd_q.size() != 0) check("rd_addr", mem_if.rd_addr, exp_rd_q.pop_front());
            end
            if (mem_if.wr_en) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                check("wr_expected", W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("wr_addr", mem_if.wr_addr, exp_addr_q.pop_front());
                    check("wr_data", mem_if.wr_data, exp_q.pop_front());
                    check("wr_cycle", cyc, exp_cyc_q.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] v);
        sram[a]    = v;
        ref_mem[a] = v;
    endtask

    task automatic start_pass(input logic [1:0] mode, input logic relu,
                              input logic [AW-1:0] base, input logic [LW-1:0] len);
        cfg_start = 1'b1; cfg_mode = mode; cfg_relu = relu; cfg_base = base; cfg_len = len;
        p_mode = mode; p_relu = relu; p_base = base; p_idx = 0;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic beat(input logic [W-1:0] data);
        logic [AW-1:0] a;
        logic [W-1:0]  e;
        a = p_base + AW'(p_idx);
        p_idx++;
        conv_valid = 1'b1;
        conv_data  = data;
        if (p_mode != MODE_FIRST) exp_rd_q.push_back(a);
        e = model(ref_mem.exists(a) ? ref_mem[a] : '0, data, p_mode, p_relu);
        ref_mem[a] = e;
        exp_q.push_back(e);
        exp_addr_q.push_back(a);
        exp_cyc_q.push_back(cyc + 2 + AL);
        tick();
        conv_valid = 1'b0;
        conv_data  = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, W'(seen), 1);
        if (seen) check({tag, "_done_lat"}, cyc, last_wr_cyc + 1);
        tick();
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] w;
        int wr0, rd0, dn0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", mem_if.wr_en, 0);
        check("rst_rd_en", mem_if.rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_unexp, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        tick();

        // 1: reset in the middle of an ACCUM pass
        for (int i = 0; i < 8; i++) preload(AW'(16'h40 + i), lanes4(i, i, i, i));
        start_pass(MODE_ACCUM, 1'b0, 16'h40, 8);
        repeat (3) beat(lanes4(1, 1, 1, 1));
        #2 rst = 1'b1;
        #1;
        check("midrst_wr_en", mem_if.wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete(); exp_rd_q.delete();
        wr0 = wr_cnt; dn0 = done_cnt;
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) tick();
        check("midrst_no_wr", wr_cnt, wr0);
        check("midrst_no_done", done_cnt, dn0);
        check("midrst_idle", busy, 0);

        // 2: FIRST pass, back-to-back
        rd0 = rd_cnt;
        start_pass(MODE_FIRST, 1'b0, 16'h10, 4);
        for (int k = 0; k < 4; k++) beat(lanes4(1 + k, 2 + k, 3 + k, 4 + k));
        wait_done("first", 30);
        check("first_no_rd", rd_cnt, rd0);

        // 3: ACCUM over the same region (+5 per lane)
        rd0 = rd_cnt;
        start_pass(MODE_ACCUM, 1'b0, 16'h10, 4);
        for (int k = 0; k < 4; k++) beat(lanes4(5, 5, 5, 5));
        wait_done("accum", 30);
        check("accum_rd_cnt", rd_cnt, rd0 + 4);
        w = sram[16'h13];
        check("accum_word3", w, lanes4(9, 10, 11, 12));

        // 4: saturation and ReLU on LAST
        for (int pass = 0; pass < 2; pass++) begin
            preload(16'h20, lanes4(32'h7FFFFFF0, 10, 32'hFFFFFFFF, 0));
            preload(16'h21, lanes4(32'hFFFFFFF9, 100, 32'h80000000, 0));
            start_pass(MODE_LAST, (pass == 0), 16'h20, 2);
            beat(lanes4(32'h20, 5, 32'hFFFFFFFD, 0));
            beat(lanes4(2, 32'hFFFFFF38, 32'hFFFFFFFF, 7));
            wait_done(pass == 0 ? "relu" : "norelu", 30);
            w = sram[16'h20];
            check("sat_hi_lane0", w[31:0], 32'h7FFFFFFF);
            w = sram[16'h21];
            check("neg_lane0", w[31:0], (pass == 0) ? 32'h0 : 32'hFFFFFFFB);
            check("sat_lo_lane2", w[95:64], (pass == 0) ? 32'h0 : 32'h80000000);
        end

        // 5: address wrap with gaps in conv_valid
        for (int i = 0; i < 4; i++) preload(AW'(16'hFFFE + i), lanes4(i, 2 * i, 3 * i, 4 * i));
        start_pass(MODE_ACCUM, 1'b0, 16'hFFFE, 4);
        beat(lanes4(1, 2, 3, 4));
        tick();
        beat(lanes4(5, 6, 7, 8));
        beat(lanes4(9, 10, 11, 12));
        tick();
        beat(lanes4(13, 14, 15, 16));
        wait_done("wrap", 30);
        w = sram[16'h0001];
        check("wrap_word", w, lanes4(16, 20, 24, 28));

        // 6: error flag and edge cases
        conv_valid = 1'b1; conv_data = lanes4(1, 1, 1, 1);
        tick();
        conv_valid = 1'b0;
        check("err_idle_beat", err_unexp, 1);
        wr0 = wr_cnt; rd0 = rd_cnt;
        start_pass(MODE_ACCUM, 1'b0, 16'h30, 0);
        check("len0_done", done, 1);
        check("len0_err_clr", err_unexp, 0);
        tick();
        check("len0_done_end", done, 0);
        check("len0_idle", busy, 0);
        check("len0_no_wr", wr_cnt, wr0);
        check("len0_no_rd", rd_cnt, rd0);

        start_pass(MODE_FIRST, 1'b0, 16'h80, 4);
        beat(lanes4(7, 7, 7, 7));
        beat(lanes4(8, 8, 8, 8));
        cfg_start = 1'b1; cfg_mode = MODE_LAST; cfg_base = 16'h90; cfg_len = 2;
        beat(lanes4(9, 9, 9, 9));
        cfg_start = 1'b0;
        beat(lanes4(10, 10, 10, 10));
        check("restart_ign_err", err_unexp, 0);
        conv_valid = 1'b1;
        tick();
        conv_valid = 1'b0;
        check("err_drain_beat", err_unexp, 1);
        wait_done("restart", 30);
        start_pass(MODE_FIRST, 1'b0, 16'h00, 0);
        check("err_clr_start", err_unexp, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
